ram_access_arbiter: RTL

- Arbitrates the single-port data RAM between the CPU MEM stage and an external host port (program/data loader, debug reader).
- Sequences every access as issue, RAM latency, response, and returns a one-cycle ack to the winning requester.
- The stage controller uses cpu_stall to hold the pipeline-register and RAM write enables until the CPU access completes.

---
 rtl/ram_access_arbiter_if.sv | 49 ++++
 rtl/ram_access_arbiter.sv | 114 +++++++++++
 2 files changed

// File: rtl/ram_access_arbiter_if.sv
// CPU-port, external-port and RAM-side signals of the data-RAM access arbiter.
// The arbiter connects through the slave modport; requesters and the RAM model use master.
interface ram_access_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;

    logic                  ext_req;
    logic                  ext_we;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic [DATA_WIDTH-1:0] ext_rdata;
    logic                  ext_ack;
    logic                  ext_stall;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_rdata;

    logic                  busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack, ext_stall,
        output ram_addr, ram_wdata, ram_wren,
        input  ram_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack, ext_stall,
        input  ram_addr, ram_wdata, ram_wren,
        output ram_rdata,
        input  busy
    );
endinterface

// File: rtl/ram_access_arbiter.sv
// Arbitrates a single-port synchronous-read RAM between the CPU MEM stage and an
// external host port; each access runs IDLE -> ISSUE -> WAIT -> RESP with a one-cycle ack.
module ram_access_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_access_arbiter_if.slave   bus
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_EXT
    } grant_t;

    state_t                r_state;
    grant_t                r_grant;
    logic                  r_gnt_we;
    logic [STREAK_W-1:0]   r_streak;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_wdata;
    logic                  r_ram_wren;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ext_rdata;
    logic                  r_cpu_ack;
    logic                  r_ext_ack;

    logic                  w_starved;
    logic                  w_ext_wins;
    logic [STREAK_W-1:0]   w_streak_inc;

    // The external port wins when the CPU is idle or has been granted too often in a row.
    assign w_starved    = (r_streak >= STREAK_W'(STARVE_LIMIT));
    assign w_ext_wins   = bus.ext_req & (~bus.cpu_req | w_starved);
    assign w_streak_inc = w_starved ? r_streak : r_streak + STREAK_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= GNT_CPU;
            r_gnt_we    <= 1'b0;
            r_streak    <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_wren  <= 1'b0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_ext_ack   <= 1'b0;
        end else begin
            r_ram_wren <= 1'b0;
            r_cpu_ack  <= 1'b0;
            r_ext_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ext_wins) begin
                        r_state     <= ST_ISSUE;
                        r_grant     <= GNT_EXT;
                        r_gnt_we    <= bus.ext_we;
                        r_ram_addr  <= bus.ext_addr;
                        r_ram_wdata <= bus.ext_wdata;
                        r_ram_wren  <= bus.ext_we;
                        r_streak    <= '0;
                    end else if (bus.cpu_req) begin
                        r_state     <= ST_ISSUE;
                        r_grant     <= GNT_CPU;
                        r_gnt_we    <= bus.cpu_we;
                        r_ram_addr  <= bus.cpu_addr;
                        r_ram_wdata <= bus.cpu_wdata;
                        r_ram_wren  <= bus.cpu_we;
                        r_streak    <= bus.ext_req ? w_streak_inc : '0;
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT;
                // RAM read data is valid in WAIT; capture it and ack the granted port.
                ST_WAIT: begin
                    r_state <= ST_RESP;
                    if (r_grant == GNT_EXT) begin
                        r_ext_ack <= 1'b1;
                        if (!r_gnt_we) r_ext_rdata <= bus.ram_rdata;
                    end else begin
                        r_cpu_ack <= 1'b1;
                        if (!r_gnt_we) r_cpu_rdata <= bus.ram_rdata;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.cpu_ack   = r_cpu_ack;
    assign bus.cpu_stall = bus.cpu_req & ~r_cpu_ack;
    assign bus.ext_rdata = r_ext_rdata;
    assign bus.ext_ack   = r_ext_ack;
    assign bus.ext_stall = bus.ext_req & ~r_ext_ack;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.ram_wren  = r_ram_wren;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule
